// File: rtl/ysyx_220066_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_220066_ifu -- instruction fetch unit feeding the decode stage.
//
// Owns the program counter and keeps at most one fetch outstanding towards
// instruction memory. Each returned 32-bit instruction is parked, together
// with its PC and a fault flag, in a single-entry buffer that decode drains
// with a valid/ready handshake. Execute may redirect the PC at any time.
// `halt` stops new requests. Misaligned targets and memory access errors
// produce a fault entry, after which fetching stops until the next redirect.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-high reset
//   redirect_valid   execute requests a PC change this cycle
//   redirect_pc      new PC when redirect_valid is high
//   halt             level; while high no new fetch request is issued
//   imem_req_valid   fetch request valid (only in REQ with an aligned PC)
//   imem_req_ready   memory accepts the request
//   imem_req_addr    fetch address, always the current PC
//   imem_resp_valid  memory response valid
//   imem_resp_ready  IFU accepts the response
//   imem_resp_data   fetched instruction word
//   imem_resp_err    access fault on this response
//   out_valid        buffer holds an entry for decode
//   out_ready        decode consumes the buffer this cycle
//   out_instr        buffered instruction
//   out_pc           PC of the buffered instruction
//   out_fault        buffered entry is a fetch fault
// ---------------------------------------------------------------------------
module ysyx_220066_ifu #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    output logic            imem_resp_ready,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    // Set when the outstanding response belongs to a fetch that a redirect
    // has made stale; that response is accepted and thrown away.
    logic            r_drop;
    logic            r_out_valid;
    logic [31:0]     r_out_instr;
    logic [XLEN-1:0] r_out_pc;
    logic            r_out_fault;

    logic            w_pc_misaligned;
    logic            w_buf_free;
    logic            w_req_fire;
    logic            w_resp_fire;
    state_t          w_resume_state;

    // A misaligned PC can only come from a redirect. It never reaches memory;
    // the REQ state turns it into a fault entry instead.
    assign w_pc_misaligned = (r_pc[1:0] != 2'b00);

    // The buffer can take a new entry if it is empty or drained this cycle.
    assign w_buf_free      = !r_out_valid || out_ready;

    assign imem_req_valid  = (r_state == S_REQ) && !w_pc_misaligned;
    assign imem_req_addr   = r_pc;

    // Stale responses are always accepted so they cannot block the port.
    assign imem_resp_ready = (r_state == S_WAIT) && (r_drop || w_buf_free);

    assign w_req_fire      = imem_req_valid && imem_req_ready;
    assign w_resp_fire     = imem_resp_valid && imem_resp_ready;

    // Where the FSM goes after a completed (or discarded) fetch.
    assign w_resume_state  = halt ? S_IDLE : S_REQ;

    assign out_valid       = r_out_valid;
    assign out_instr       = r_out_instr;
    assign out_pc          = r_out_pc;
    assign out_fault       = r_out_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_pc    <= '0;
            r_out_fault <= 1'b0;
        end else begin
            // Decode draining the entry empties the buffer; a load further
            // down overrides this, giving the drain-and-refill case.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (redirect_valid) begin
                r_pc        <= redirect_pc;
                r_out_valid <= 1'b0;
                if (w_resp_fire) begin
                    // The response arriving now is simply not loaded.
                    r_drop  <= 1'b0;
                    r_state <= S_REQ;
                end else if ((r_state == S_WAIT) || w_req_fire) begin
                    // A fetch is (or is becoming) outstanding: wait for its
                    // response and discard it before fetching the new target.
                    r_drop  <= 1'b1;
                    r_state <= S_WAIT;
                end else begin
                    r_drop  <= 1'b0;
                    r_state <= S_REQ;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!halt) begin
                            r_state <= S_REQ;
                        end
                    end

                    S_REQ: begin
                        if (w_pc_misaligned) begin
                            // Report the bad target instead of fetching it.
                            if (w_buf_free) begin
                                r_out_valid <= 1'b1;
                                r_out_instr <= 32'd0;
                                r_out_pc    <= r_pc;
                                r_out_fault <= 1'b1;
                                r_state     <= S_FAULT;
                            end else if (halt) begin
                                r_state <= S_IDLE;
                            end
                        end else if (w_req_fire) begin
                            r_state <= S_WAIT;
                        end else if (halt) begin
                            r_state <= S_IDLE;
                        end
                    end

                    S_WAIT: begin
                        if (w_resp_fire) begin
                            if (r_drop) begin
                                r_drop  <= 1'b0;
                                r_state <= w_resume_state;
                            end else begin
                                r_out_valid <= 1'b1;
                                r_out_instr <= imem_resp_data;
                                r_out_pc    <= r_pc;
                                r_out_fault <= imem_resp_err;
                                if (imem_resp_err) begin
                                    r_state <= S_FAULT;
                                end else begin
                                    // Wraps silently at the top of the space.
                                    r_pc    <= r_pc + PC_STEP;
                                    r_state <= w_resume_state;
                                end
                            end
                        end
                    end

                    S_FAULT: begin
                        // Parked until a redirect picks a new target.
                        r_state <= S_FAULT;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220066_ifu.sv
module tb_ysyx_220066_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_fault;

    ysyx_220066_ifu #(
        .XLEN     (64),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_fault       (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int delivered = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- memory contents and reference model -----------------
    function automatic logic [31:0] memf(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic errf(input logic [63:0] a);
        return (a == 64'h0000_0000_8000_0010) || (a[9:2] == 8'hA7);
    endfunction

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        exp_q[$];
    logic [63:0] m_pc;
    bit          m_stop;

    // Program order: consecutive words from the last target, ending with the
    // first faulting entry (misaligned target or memory error).
    task automatic refill();
        ent_t e;
        while (exp_q.size() < 4 && !m_stop) begin
            e.pc = m_pc;
            if (m_pc[1:0] != 2'b00) begin
                e.instr = 32'd0;
                e.fault = 1'b1;
            end else begin
                e.instr = memf(m_pc);
                e.fault = errf(m_pc);
            end
            exp_q.push_back(e);
            if (e.fault) m_stop = 1'b1;
            else         m_pc   = m_pc + 64'd4;
        end
    endtask

    task automatic model_restart(input logic [63:0] pc);
        exp_q.delete();
        m_pc   = pc;
        m_stop = 1'b0;
        refill();
    endtask

    // ---------------- memory responder ----------------
    bit          mem_random = 1'b0;
    int          fixed_lat  = 0;
    bit          pending    = 1'b0;
    logic [63:0] pend_addr  = '0;
    int          lat        = 0;

    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        imem_resp_err   = 1'b0;
    end

    always begin
        bit          s_req;
        bit          s_resp;
        logic [63:0] s_addr;
        @(negedge clk);
        s_req  = imem_req_valid && imem_req_ready;
        s_resp = imem_resp_valid && imem_resp_ready;
        s_addr = imem_req_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (s_resp) pending = 1'b0;
            if (s_req) begin
                pending   = 1'b1;
                pend_addr = s_addr;
                lat       = mem_random ? int'($urandom_range(0, 3)) : fixed_lat;
            end else if (pending && lat > 0) begin
                lat--;
            end
        end
        imem_resp_valid = pending && (lat == 0);
        imem_resp_data  = pending ? memf(pend_addr) : 32'd0;
        imem_resp_err   = pending && errf(pend_addr);
        imem_req_ready  = mem_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    bit          prev_hold  = 1'b0;
    bit          prev_halt  = 1'b0;
    bit          prev_redir = 1'b0;
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    logic        hold_fault;

    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            model_restart(RESET_PC);
            prev_hold  = 1'b0;
            prev_halt  = 1'b0;
            prev_redir = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_pc", out_pc, hold_pc);
                chk("hold_instr", 64'(out_instr), 64'(hold_instr));
                chk("hold_fault", 64'(out_fault), 64'(hold_fault));
            end
            if (prev_halt && halt && !prev_redir)
                chk("halt_no_req", 64'(imem_req_valid), 64'd0);
            if (imem_req_valid)
                chk("req_align", 64'(imem_req_addr[1:0]), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_empty: got entry pc=%h, required no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", 64'(out_instr), 64'(e.instr));
                    chk("sb_fault", 64'(out_fault), 64'(e.fault));
                    refill();
                end
                delivered++;
                $display("entry pc=%h instr=%h fault=%0d", out_pc, out_instr, out_fault);
            end
            if (redirect_valid) model_restart(redirect_pc);
            prev_hold  = out_valid && !out_ready && !redirect_valid;
            hold_pc    = out_pc;
            hold_instr = out_instr;
            hold_fault = out_fault;
            prev_halt  = halt;
            prev_redir = redirect_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          cnt;
        bit          seen;
        logic [63:0] s_pc;
        logic [31:0] s_instr;
        logic [63:0] t;
        int          r;
        int          del_before;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_resp_ready", 64'(imem_resp_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_fault", 64'(out_fault), 64'd0);

        // Continuous fetch with zero-latency memory.
        out_ready = 1'b1;
        rst = 1'b0;
        chk("release_no_req", 64'(imem_req_valid), 64'd0);
        step();
        chk("req0_valid", 64'(imem_req_valid), 64'd1);
        chk("req0_addr", imem_req_addr, 64'h8000_0000);
        step();
        chk("wait0_no_req", 64'(imem_req_valid), 64'd0);
        step();
        chk("out0_valid", 64'(out_valid), 64'd1);
        chk("out0_pc", out_pc, 64'h8000_0000);
        chk("req1_valid", 64'(imem_req_valid), 64'd1);
        chk("req1_addr", imem_req_addr, 64'h8000_0004);
        step(); step();
        chk("out1_pc", out_pc, 64'h8000_0004);
        chk("out1_fault", 64'(out_fault), 64'd0);
        chk("req2_addr", imem_req_addr, 64'h8000_0008);

        // The stream runs into the access error at 0x80000010.
        for (int n = 0; n < 60 && !(out_valid && out_fault); n++) step();
        chk("err_seen", 64'(out_valid && out_fault), 64'd1);
        chk("err_pc", out_pc, 64'h8000_0010);
        cnt = 0;
        repeat (10) begin step(); if (imem_req_valid) cnt++; end
        chk("err_no_req", 64'(cnt), 64'd0);

        // Redirect while waiting for the 0x80000008 response.
        fixed_lat = 3;
        do_redirect(64'h8000_0000);
        for (int n = 0; n < 60 && !(pending && pend_addr == 64'h8000_0008); n++) step();
        chk("wait8_reached", 64'(pending && pend_addr == 64'h8000_0008), 64'd1);
        do_redirect(64'h8000_1000);
        chk("redir_flush", 64'(out_valid), 64'd0);
        for (int n = 0; n < 20 && !imem_req_valid; n++) step();
        chk("redir_req_addr", imem_req_addr, 64'h8000_1000);
        for (int n = 0; n < 40 && !out_valid; n++) step();
        chk("redir_out_pc", out_pc, 64'h8000_1000);

        // Backpressure from decode.
        out_ready = 1'b0;
        for (int n = 0; n < 60 && !(out_valid && imem_resp_valid); n++) step();
        chk("bp_reached", 64'(out_valid && imem_resp_valid), 64'd1);
        chk("bp_resp_ready", 64'(imem_resp_ready), 64'd0);
        s_pc = out_pc; s_instr = out_instr;
        repeat (3) step();
        chk("bp_hold_pc", out_pc, s_pc);
        chk("bp_hold_instr", 64'(out_instr), 64'(s_instr));
        chk("bp_resp_ready2", 64'(imem_resp_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(imem_resp_ready), 64'd1);
        step();
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_pc", out_pc, s_pc + 64'd4);

        // Misaligned redirect target.
        do_redirect(64'h8000_0002);
        cnt = 0; seen = 1'b0; s_pc = '0; s_instr = '1;
        repeat (12) begin
            if (imem_req_valid) cnt++;
            if (out_valid && out_fault && !seen) begin seen = 1'b1; s_pc = out_pc; s_instr = out_instr; end
            step();
        end
        chk("mis_no_req", 64'(cnt), 64'd0);
        chk("mis_seen", 64'(seen), 64'd1);
        chk("mis_pc", s_pc, 64'h8000_0002);
        chk("mis_instr", 64'(s_instr), 64'd0);
        do_redirect(64'h8000_0100);
        for (int n = 0; n < 20 && !imem_req_valid; n++) step();
        chk("mis_resume_addr", imem_req_addr, 64'h8000_0100);

        // Halt after the second request has been accepted.
        fixed_lat = 2;
        do_redirect(64'h8000_3000);
        for (int n = 0; n < 60 && !(pending && pend_addr == 64'h8000_3004); n++) step();
        chk("halt_reached", 64'(pending && pend_addr == 64'h8000_3004), 64'd1);
        halt = 1'b1;
        cnt = 0; seen = 1'b0;
        repeat (15) begin
            step();
            if (imem_req_valid) cnt++;
            if (out_valid && out_pc == 64'h8000_3004) seen = 1'b1;
        end
        chk("halt_delivered", 64'(seen), 64'd1);
        chk("halt_req_count", 64'(cnt), 64'd0);
        halt = 1'b0;

        // Asynchronous reset in the middle of a fetch.
        for (int n = 0; n < 40 && !pending; n++) step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("arst_resp_ready", 64'(imem_resp_ready), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_pc", out_pc, 64'd0);
        chk("arst_out_instr", 64'(out_instr), 64'd0);
        chk("arst_out_fault", 64'(out_fault), 64'd0);
        step(); step();
        rst = 1'b0;
        for (int n = 0; n < 10 && !imem_req_valid; n++) step();
        chk("arst_first_addr", imem_req_addr, RESET_PC);

        // Randomized traffic.
        mem_random = 1'b1;
        del_before = delivered;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) halt = !halt;
            if (redirect_valid) begin
                redirect_valid = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
                r = int'($urandom_range(0, 7));
                t = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
                if (r == 0)      t = t + 64'($urandom_range(1, 3));
                else if (r == 1) t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
                redirect_valid = 1'b1;
                redirect_pc    = t;
            end
            step();
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
        out_ready = 1'b1;
        do_redirect(64'h8000_0400);
        repeat (60) step();
        chk("random_progress", 64'(delivered > del_before + 100), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
